// File: rtl/nios_system_cpu_div_cell_pkg.sv
// Shared definitions for the Nios II M-stage divider cell: FSM states,
// default operand width and the divide-by-zero quotient constant.
package nios_system_CPU_div_pkg;

  localparam int DIV_WIDTH = 32;

  // Wide enough for any supported WIDTH; the cell slices it down.
  localparam logic [63:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIXUP,
    DONE
  } div_state_t;

endpackage

// File: rtl/nios_system_cpu_div_cell_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// subtract the divisor if the shifted remainder is large enough.
module nios_system_CPU_div_step
  #(parameter int WIDTH = 32)
  (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] new_rem,
    output logic             q_bit
  );

  logic [WIDTH:0] trial;

  // The running remainder stays below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the top bit of the difference is its sign.
  assign trial   = {rem, dvd_msb} - {1'b0, divisor};
  assign q_bit   = ~trial[WIDTH];
  assign new_rem = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dvd_msb};

endmodule

// File: rtl/nios_system_cpu_div_cell.sv
// Multi-cycle signed/unsigned restoring divider for the Nios II M-stage.
// One quotient bit per clock; results and flags are fully registered.
module nios_system_cpu_div_cell
  import nios_system_CPU_div_pkg::*;
  #(parameter int WIDTH = DIV_WIDTH)
  (
    input  logic             clk,
    input  logic             reset,
    input  logic             M_div_start,
    input  logic             M_div_signed,
    input  logic [WIDTH-1:0] M_div_src1,
    input  logic [WIDTH-1:0] M_div_src2,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_cell_quotient,
    output logic [WIDTH-1:0] M_div_cell_remainder,
    output logic             M_div_by_zero
  );

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ZERO_QUOT = DIV_ZERO_QUOT[WIDTH-1:0];
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  div_state_t       state;
  logic             op_signed;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic             q_neg;
  logic             r_neg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] step_rem;
  logic             step_q_bit;

  // Two's-complement negate when requested; MIN wraps to itself, which
  // gives the architecturally expected MIN / -1 result.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  nios_system_CPU_div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .dvd_msb (dvd[WIDTH-1]),
    .divisor (divisor),
    .new_rem (step_rem),
    .q_bit   (step_q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      op_signed            <= 1'b0;
      src1                 <= '0;
      src2                 <= '0;
      dvd                  <= '0;
      rem                  <= '0;
      divisor              <= '0;
      q_neg                <= 1'b0;
      r_neg                <= 1'b0;
      cnt                  <= '0;
      M_div_busy           <= 1'b0;
      M_div_done           <= 1'b0;
      M_div_cell_quotient  <= '0;
      M_div_cell_remainder <= '0;
      M_div_by_zero        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          M_div_done <= 1'b0;
          if (M_div_start) begin
            src1       <= M_div_src1;
            src2       <= M_div_src2;
            op_signed  <= M_div_signed;
            M_div_busy <= 1'b1;
            state      <= PREP;
          end
        end
        // Convert to magnitudes and remember the result signs.
        PREP: begin
          dvd     <= apply_sign(src1, op_signed & src1[WIDTH-1]);
          divisor <= apply_sign(src2, op_signed & src2[WIDTH-1]);
          q_neg   <= op_signed & (src1[WIDTH-1] ^ src2[WIDTH-1]);
          r_neg   <= op_signed & src1[WIDTH-1];
          rem     <= '0;
          cnt     <= CNT_LAST;
          state   <= RUN;
        end
        // Quotient bits accumulate in the dividend register as it drains.
        RUN: begin
          rem <= step_rem;
          dvd <= {dvd[WIDTH-2:0], step_q_bit};
          if (cnt == '0) begin
            state <= FIXUP;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        FIXUP: begin
          if (src2 == '0) begin
            M_div_cell_quotient  <= ZERO_QUOT;
            M_div_cell_remainder <= src1;
            M_div_by_zero        <= 1'b1;
          end else begin
            M_div_cell_quotient  <= apply_sign(dvd, q_neg);
            M_div_cell_remainder <= apply_sign(rem, r_neg);
            M_div_by_zero        <= 1'b0;
          end
          M_div_done <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          M_div_done <= 1'b0;
          M_div_busy <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_system_cpu_div_cell.sv
// Directed bench for the divider cell: table of operand/result vectors plus
// hand-written sequences for busy re-start, start-in-DONE and mid-run reset.
module tb_nios_system_cpu_div_cell;

  localparam int W = 32;
  localparam int EXP_LAT = 34;
  localparam int LAT_LIMIT = 80;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } rec_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic         sgn;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         busy;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         by_zero;

  int checks;
  int failures;

  rec_t vec [13];

  nios_system_cpu_div_cell #(.WIDTH(W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .M_div_start          (start),
    .M_div_signed         (sgn),
    .M_div_src1           (src1),
    .M_div_src2           (src2),
    .M_div_busy           (busy),
    .M_div_done           (done),
    .M_div_cell_quotient  (quot),
    .M_div_cell_remainder (rem),
    .M_div_by_zero        (by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one operation and wait for done; checks busy throughout, latency,
  // results and that the previous done pulse lasted a single cycle.
  task automatic run_op(input string name, input rec_t v, input int hold_cycles);
    int lat;
    logic busy_ok;
    @(negedge clk);
    chk({name, "_idle_done"}, {31'b0, done}, 32'd0);
    chk({name, "_idle_busy"}, {31'b0, busy}, 32'd0);
    start = 1'b1;
    sgn   = v.sgn;
    src1  = v.a;
    src2  = v.b;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_ok = busy;
    while (!done && lat < LAT_LIMIT) begin
      if (lat == hold_cycles) begin
        start = 1'b1;
        src1  = 32'd7;
        src2  = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    chk({name, "_latency"}, lat, EXP_LAT);
    chk({name, "_busy"}, {31'b0, busy_ok}, 32'd1);
    chk({name, "_quot"}, quot, v.q);
    chk({name, "_rem"}, rem, v.r);
    chk({name, "_by_zero"}, {31'b0, by_zero}, {31'b0, v.z});
  endtask

  initial begin
    int seen;
    checks   = 0;
    failures = 0;
    reset = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    src1  = '0;
    src2  = '0;

    vec[0]  = '{1'b0, 32'd100,       32'd7,       32'd14,      32'd2,       1'b0};
    vec[1]  = '{1'b1, 32'hFFFF_FF9C, 32'd7,       32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    vec[2]  = '{1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,     1'b0};
    vec[3]  = '{1'b0, 32'h0000_1234, 32'd0,       32'hFFFF_FFFF, 32'h0000_1234, 1'b1};
    vec[4]  = '{1'b0, 32'd100,       32'd7,       32'd14,      32'd2,       1'b0};
    vec[5]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,   1'b0};
    vec[6]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF, 32'd0,     1'b0};
    vec[7]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,    32'hFFFF_FFFE, 1'b0};
    vec[8]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,     32'd0,       1'b0};
    vec[9]  = '{1'b0, 32'd5,         32'd10,      32'd0,       32'd5,       1'b0};
    vec[10] = '{1'b1, 32'hFFFF_FFFF, 32'd0,       32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    vec[11] = '{1'b0, 32'h8000_0000, 32'd3,       32'h2AAA_AAAA, 32'd2,     1'b0};
    vec[12] = '{1'b1, 32'd7,         32'h8000_0000, 32'd0,     32'd7,       1'b0};

    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_by_zero", {31'b0, by_zero}, 32'd0);
    chk("reset_quot", quot, 32'd0);
    chk("reset_rem", rem, 32'd0);
    reset = 1'b0;

    // Consecutive table entries are issued back-to-back after DONE.
    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vec[i], -1);
    end

    // Start re-pulsed mid-run must not disturb the operation in flight.
    run_op("repulse", '{1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0}, 5);

    // Start held during the DONE cycle is ignored.
    start = 1'b1;
    src1  = 32'd9;
    src2  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_busy", {31'b0, busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("start_in_done_ignored", seen, 0);
    chk("start_in_done_quot", quot, 32'd333);

    // Reset partway through RUN clears everything with no done pulse.
    @(negedge clk);
    start = 1'b1;
    sgn   = 1'b0;
    src1  = 32'd1000;
    src2  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrun_reset_busy", {31'b0, busy}, 32'd0);
    chk("midrun_reset_done", {31'b0, done}, 32'd0);
    chk("midrun_reset_quot", quot, 32'd0);
    chk("midrun_reset_rem", rem, 32'd0);
    chk("midrun_reset_by_zero", {31'b0, by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("no_done_after_reset", seen, 0);
    run_op("after_reset", '{1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0}, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
